// File: rtl/ascon_arbiter_if.sv
// Bundle of request/block/core handshake signals between the two requesters,
// the arbiter and the shared ASCON-128 core.
interface ascon_arbiter_if #(
  parameter int DATA_W = 64
);
  logic [1:0]        req_i;
  logic [1:0]        gnt_o;
  logic [1:0]        blk_valid_i;
  logic [1:0]        blk_ready_o;
  logic [DATA_W-1:0] blk_data0_i;
  logic [DATA_W-1:0] blk_data1_i;
  logic              core_start_o;
  logic              core_data_valid_o;
  logic [DATA_W-1:0] core_data_o;
  logic              core_xor_up_i;
  logic              core_cipher_valid_i;
  logic              core_end_i;
  logic [1:0]        cipher_valid_o;
  logic [1:0]        done_o;
  logic              busy_o;

  // Arbiter side
  modport slave (
    input  req_i, blk_valid_i, blk_data0_i, blk_data1_i,
    input  core_xor_up_i, core_cipher_valid_i, core_end_i,
    output gnt_o, blk_ready_o, core_start_o, core_data_valid_o, core_data_o,
    output cipher_valid_o, done_o, busy_o
  );

  // Requester/core side
  modport master (
    output req_i, blk_valid_i, blk_data0_i, blk_data1_i,
    output core_xor_up_i, core_cipher_valid_i, core_end_i,
    input  gnt_o, blk_ready_o, core_start_o, core_data_valid_o, core_data_o,
    input  cipher_valid_o, done_o, busy_o
  );
endinterface

// File: rtl/ascon_arbiter.sv
// Two-requester session arbiter/sequencer for a shared ASCON-128 core.
// Optional ARB_FIXED_PRIO_EN: requester 0 always wins contention instead of round-robin.
module ascon_arbiter #(
  parameter int DATA_W = 64,
  parameter int N_BLK  = 4
) (
  input  logic            clock_i,
  input  logic            resetb_i,
  ascon_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(N_BLK) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BLK);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    FEED     = 3'd2,
    WAIT_END = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e            state_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic              core_start_q;
  logic              full_q;
  logic [DATA_W-1:0] hold_q;
  logic [CNT_W-1:0]  blk_cnt_q;

  logic              win_d;
  logic [CNT_W-1:0]  blk_cnt_d;
  logic [1:0]        blk_ready;
  logic              load;
  logic              consume;
  logic [DATA_W-1:0] blk_data_sel;

  // win_d = index of the requester that gets the next session
`ifdef ARB_FIXED_PRIO_EN
  assign win_d = ~bus.req_i[0];
`else
  logic last_q;
  assign win_d = (&bus.req_i) ? ~last_q : bus.req_i[1];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign blk_ready[gi]          = (state_q == FEED) & gnt_q[gi] & ~full_q;
      assign bus.cipher_valid_o[gi] = bus.core_cipher_valid_i & gnt_q[gi];
    end
  endgenerate

  // ready is ~full_q, so a load and a consume are mutually exclusive
  assign load         = |(bus.blk_valid_i & blk_ready);
  assign consume      = (state_q == FEED) & full_q & bus.core_xor_up_i;
  assign blk_cnt_d    = blk_cnt_q + 1'b1;
  assign blk_data_sel = gnt_q[1] ? bus.blk_data1_i : bus.blk_data0_i;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      core_start_q <= 1'b0;
      full_q       <= 1'b0;
      hold_q       <= '0;
      blk_cnt_q    <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_q       <= 1'b1;
`endif
    end else begin
      core_start_q <= 1'b0;
      done_q       <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|bus.req_i) begin
            gnt_q        <= win_d ? 2'b10 : 2'b01;
            core_start_q <= 1'b1;
            blk_cnt_q    <= '0;
            full_q       <= 1'b0;
            state_q      <= START;
          end
        end
        START: begin
          state_q <= FEED;
        end
        FEED: begin
          if (load) begin
            hold_q <= blk_data_sel;
            full_q <= 1'b1;
          end else if (consume) begin
            full_q    <= 1'b0;
            blk_cnt_q <= blk_cnt_d;
            if (blk_cnt_d == CNT_LAST) begin
              state_q <= WAIT_END;
            end
          end
        end
        WAIT_END: begin
          if (bus.core_end_i) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // done pulse and grant release happen together on leaving DONE
          done_q    <= gnt_q;
          gnt_q     <= 2'b00;
          blk_cnt_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
          last_q    <= gnt_q[1];
`endif
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_o             = gnt_q;
  assign bus.blk_ready_o       = blk_ready;
  assign bus.core_start_o      = core_start_q;
  assign bus.core_data_valid_o = full_q;
  assign bus.core_data_o       = hold_q;
  assign bus.done_o            = done_q;
  assign bus.busy_o            = (state_q != IDLE);

endmodule
